// File: rtl/bcd_conv_arbiter_if.sv
// Handshake bundle between two binary requesters, the shared BCD converter and its consumer.
interface bcd_conv_arbiter_if #(
    parameter int W          = 14,
    parameter int NUM_DIGITS = 4
);
    logic                    req0_valid;
    logic [W-1:0]            req0_bin;
    logic                    req0_ready;
    logic                    req1_valid;
    logic [W-1:0]            req1_bin;
    logic                    req1_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [4*NUM_DIGITS-1:0] out_bcd;
    logic                    out_id;
    logic                    out_ovf;

    modport master (
        output req0_valid, req0_bin, req1_valid, req1_bin, out_ready,
        input  req0_ready, req1_ready, out_valid, out_bcd, out_id, out_ovf
    );

    modport slave (
        input  req0_valid, req0_bin, req1_valid, req1_bin, out_ready,
        output req0_ready, req1_ready, out_valid, out_bcd, out_id, out_ovf
    );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Round-robin shared binary-to-packed-BCD converter, one divide-by-10 per cycle per digit.
// Optional macro BCD_CONV_SATURATE_EN: overflowed results are forced to all nines.
module bcd_conv_arbiter #(
    parameter int W          = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_conv_arbiter_if.slave   bus
);
    localparam int              BW   = 4 * NUM_DIGITS;
    localparam int              CW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0]   LAST = CW'(NUM_DIGITS - 1);
    localparam logic [W-1:0]    TEN  = W'(10);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic [W-1:0]    q_q, q_d;
    logic [BW-1:0]   sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [BW-1:0]   out_bcd_q, out_bcd_d;
    logic            out_id_q, out_id_d;
    logic            out_ovf_q, out_ovf_d;

    logic [W-1:0]    quot;
    logic [W-1:0]    rem;
    logic            grant1;
    logic            any_req;

`ifdef BCD_CONV_SATURATE_EN
    function automatic logic [BW-1:0] saturate(input logic [BW-1:0] bcd, input logic ovf);
        return ovf ? {NUM_DIGITS{4'h9}} : bcd;
    endfunction
`endif

    // Ties go to the requester that was not served last.
    assign grant1  = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    assign any_req = bus.req0_valid || bus.req1_valid;
    assign quot    = q_q / TEN;
    assign rem     = q_q % TEN;

    assign bus.req0_ready = (state_q == IDLE) && bus.req0_valid && !grant1;
    assign bus.req1_ready = (state_q == IDLE) && grant1;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_bcd    = out_bcd_q;
    assign bus.out_id     = out_id_q;
    assign bus.out_ovf    = out_ovf_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        q_d          = q_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_bcd_d    = out_bcd_q;
        out_id_d     = out_id_q;
        out_ovf_d    = out_ovf_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    q_d          = grant1 ? bus.req1_bin : bus.req0_bin;
                    out_id_d     = grant1;
                    last_grant_d = grant1;
                    cnt_d        = '0;
                    state_d      = CONV;
                end
            end
            CONV: begin
                // Digits enter at the top so the units digit ends up in the LSBs.
                q_d   = quot;
                sr_d  = {rem[3:0], sr_q[BW-1:4]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_ovf_d   = (quot != '0);
`ifdef BCD_CONV_SATURATE_EN
                    out_bcd_d   = saturate(sr_d, quot != '0);
`else
                    out_bcd_d   = sr_d;
`endif
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            q_q          <= '0;
            sr_q         <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_bcd_q    <= '0;
            out_id_q     <= 1'b0;
            out_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            q_q          <= q_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_bcd_q    <= out_bcd_d;
            out_id_q     <= out_id_d;
            out_ovf_q    <= out_ovf_d;
        end
    end
endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Sequential binary-to-packed-BCD converter shared between two requesters.
- One divide-by-10 datapath is reused once per digit rather than unrolled, trading latency for area.
- Round-robin arbitration grants one requester at a time; the result is returned on a single valid/ready output tagged with the requester id.
- Sits between the counter/measurement blocks and the 7-segment display drivers.

Parameters:
- W, 14, width of each binary input.
- NUM_DIGITS, 4, BCD digits produced; out_bcd is 4*NUM_DIGITS bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operand.
- req0_bin  input  W  requester 0 binary operand.
- req0_ready  output  1  requester 0 operand accepted this cycle.
- req1_valid  input  1  requester 1 has an operand.
- req1_bin  input  W  requester 1 binary operand.
- req1_ready  output  1  requester 1 operand accepted this cycle.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_bcd  output  4*NUM_DIGITS  packed BCD, digit 0 (units) in bits [3:0].
- out_id  output  1  requester that owns the result.
- out_ovf  output  1  input was >= 10^NUM_DIGITS.

Behaviour:
- Reset values: out_valid=0, out_bcd=0, out_id=0, out_ovf=0, req*_ready=0, state=IDLE, last_grant=1 (so requester 0 wins the first tie).
- States:
  - IDLE: accepts one operand.
  - CONV: produces one digit per cycle for NUM_DIGITS cycles.
  - DONE: holds the result.
- IDLE arbitration, combinational:
  - Only one valid: that requester is the winner.
  - Both valid: the winner is the requester not equal to last_grant.
  - Winner's ready=1, other ready=0; ready may depend on valid.
  - Both readys are 0 outside IDLE.
- Accept edge (IDLE with winner valid):
  - q <= winner operand; out_id <= winner; last_grant <= winner.
  - Digit counter <= 0; state <= CONV.
  - The operand is sampled only on this edge; later changes to req*_bin are ignored.
- Each CONV edge:
  - d = q mod 10; q <= q / 10.
  - Shift register <= {d[3:0], shift register[4*NUM_DIGITS-1:4]}; counter++.
  - On the edge where counter == NUM_DIGITS-1: state <= DONE and out_ovf <= (q/10 != 0).
  - After NUM_DIGITS shifts, digit 0 sits at the LSBs.
- Latency: out_valid rises immediately after the NUM_DIGITS-th rising edge following the accept edge (4 with defaults).
- Conversion time is fixed and does not depend on the operand value; 0 still takes NUM_DIGITS cycles.
- DONE:
  - out_valid=1; out_bcd, out_id and out_ovf are stable until the handshake.
  - out_valid & out_ready -> IDLE next edge, out_valid <= 0.
  - The next operand cannot be accepted in the same cycle as the result handshake.
- Throughput: minimum period is NUM_DIGITS+2 cycles per conversion.
- out_bcd holds the last result in IDLE and CONV; it is only meaningful while out_valid=1.
- Arithmetic:
  - q is W bits; the divider is a constant divide-by-10 at width W.
  - Every digit is 0-9; no pseudo-tetrads are ever produced.
- Overflow (operand >= 10^NUM_DIGITS): out_bcd = operand mod 10^NUM_DIGITS, out_ovf=1, unless saturation is compiled in (see Optional Feature).
- Backpressure: out_ready low holds DONE indefinitely; requesters stall with ready=0.
- Reset mid-operation: all state clears asynchronously and the partial result is discarded. No out_valid pulse follows; requesters must re-present their operands.

Optional Feature:
- Macro: BCD_CONV_SATURATE_EN.
- Defined: when out_ovf=1, out_bcd is forced to all digits 9 (0x9999 with defaults) on the DONE transition; out_ovf is still reported.
- Undefined: the overflow result is operand mod 10^NUM_DIGITS, with out_ovf=1.

Test Plan:
- Single conversion: req0_valid=1, req0_bin=1234, out_ready=1 -> req0_ready=1 on the accept cycle; out_valid after 4 edges with out_bcd=0x1234, out_id=0, out_ovf=0; back in IDLE one edge later.
- Round-robin tie: req0 and req1 valid from reset with operands 9999 and 0 -> results in order id0 0x9999, id1 0x0000, id0 0x9999, id1 0x0000; never the same id twice while both are valid.
- Overflow: req1_bin=16383 -> out_bcd=0x6383, out_ovf=1; with BCD_CONV_SATURATE_EN -> out_bcd=0x9999, out_ovf=1.
- Backpressure: out_ready=0 for 10 cycles in DONE with req0_valid held high -> out_bcd stable and req0_ready=0 throughout; on out_ready=1, one handshake then a new accept on the following cycle.
- Reset mid-conversion: assert rst_n=0 two edges after accepting 4321 -> outputs at reset values immediately and no out_valid after release; re-presenting 4321 yields 0x4321.
- Boundaries: operands 0, 9, 10 and 9999 -> 0x0000, 0x0009, 0x0010, 0x9999, each with out_ovf=0 and identical latency.
